// File: rtl/alu_mc_if.sv
// Handshake/result bundle for alu_mc. Optional result_hi port appears when ALU_MC_HI_EN is defined.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
`ifdef ALU_MC_HI_EN
  logic [WIDTH-1:0] result_hi;
`endif

  modport master (
    output in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, result, zero, busy
`ifdef ALU_MC_HI_EN
    , input result_hi
`endif
  );

  modport slave (
    input  in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, result, zero, busy
`ifdef ALU_MC_HI_EN
    , output result_hi
`endif
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops in one clock, shift-add MUL and restoring DIVU over WIDTH clocks.
// Define ALU_MC_HI_EN to build the upper-product/remainder register and the result_hi port.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  alu_mc_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
`ifdef ALU_MC_HI_EN
  localparam int unsigned PW = 2 * WIDTH;
`else
  localparam int unsigned PW = WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_MUL  = 4'b0010, OP_DIVU = 4'b0011,
    OP_AND  = 4'b0100, OP_OR   = 4'b0101, OP_XOR  = 4'b0110, OP_SLL  = 4'b0111,
    OP_SRL  = 4'b1000, OP_EQ   = 4'b1001, OP_LTU  = 4'b1010, OP_GEU  = 4'b1011,
    OP_JALR = 4'b1100, OP_SRA  = 4'b1101, OP_LT   = 4'b1110, OP_GE   = 4'b1111
  } alu_op_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SHW-1:0]   r_cnt;
  // r_x: multiplier (shifts right) or dividend/quotient (shifts left)
  // r_y: multiplicand (shifts left) or divisor; r_acc: product or remainder
  logic [WIDTH-1:0] r_x;
  logic [PW-1:0]    r_y;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
`ifdef ALU_MC_HI_EN
  logic [WIDTH-1:0] r_hi;
`endif

  alu_op_t          w_op;
  logic             w_accept;
  logic             w_last;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic [PW-1:0]    w_mul_acc;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_divisor;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;

  assign w_op     = alu_op_t'(bus.alu_op);
  assign w_shamt  = bus.b[SHW-1:0];
  assign bus.in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_last   = (r_cnt == SHW'(WIDTH - 1));

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = bus.a + bus.b;
      OP_SUB:  w_alu = bus.a - bus.b;
      OP_AND:  w_alu = bus.a & bus.b;
      OP_OR:   w_alu = bus.a | bus.b;
      OP_XOR:  w_alu = bus.a ^ bus.b;
      OP_SLL:  w_alu = bus.a << w_shamt;
      OP_SRL:  w_alu = bus.a >> w_shamt;
      OP_EQ:   w_alu = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
      OP_LTU:  w_alu = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OP_GEU:  w_alu = {{(WIDTH-1){1'b0}}, bus.a >= bus.b};
      OP_JALR: w_alu = (bus.a + bus.b) & ~WIDTH'(1);
      OP_SRA:  w_alu = WIDTH'($signed(bus.a) >>> w_shamt);
      OP_LT:   w_alu = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_GE:   w_alu = {{(WIDTH-1){1'b0}}, $signed(bus.a) >= $signed(bus.b)};
      default: w_alu = '0;
    endcase
  end

  // One multiply step: add the shifted multiplicand when the current multiplier bit is set.
  // One divide step: bring in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    w_mul_acc = r_acc + (r_x[0] ? r_y : '0);
    w_trial   = {r_acc[WIDTH-1:0], r_x[WIDTH-1]};
    w_divisor = {1'b0, r_y[WIDTH-1:0]};
    w_ge      = (w_trial >= w_divisor);
    w_rem     = w_ge ? WIDTH'(w_trial - w_divisor) : w_trial[WIDTH-1:0];
    w_quo     = {r_x[WIDTH-2:0], w_ge};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_op == OP_MUL)       w_state_nxt = S_MUL;
          else if (w_op == OP_DIVU) w_state_nxt = S_DIV;
          else                      w_state_nxt = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_accept) begin
          if (w_op == OP_MUL)       w_state_nxt = S_MUL;
          else if (w_op == OP_DIVU) w_state_nxt = S_DIV;
          else                      w_state_nxt = S_DONE;
        end else if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
`ifdef ALU_MC_HI_EN
      r_hi     <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_x   <= (w_op == OP_MUL) ? bus.b : bus.a;
        r_y   <= PW'((w_op == OP_MUL) ? bus.a : bus.b);
        if ((w_op != OP_MUL) && (w_op != OP_DIVU)) begin
          r_result <= w_alu;
          r_zero   <= (w_alu == '0);
`ifdef ALU_MC_HI_EN
          r_hi     <= '0;
`endif
        end
      end else if (r_state == S_MUL) begin
        r_acc <= w_mul_acc;
        r_x   <= r_x >> 1;
        r_y   <= r_y << 1;
        r_cnt <= w_last ? '0 : r_cnt + SHW'(1);
        if (w_last) begin
          r_result <= w_mul_acc[WIDTH-1:0];
          r_zero   <= (w_mul_acc[WIDTH-1:0] == '0);
`ifdef ALU_MC_HI_EN
          r_hi     <= w_mul_acc[PW-1:WIDTH];
`endif
        end
      end else if (r_state == S_DIV) begin
        r_acc <= PW'(w_rem);
        r_x   <= w_quo;
        r_cnt <= w_last ? '0 : r_cnt + SHW'(1);
        if (w_last) begin
          r_result <= w_quo;
          r_zero   <= (w_quo == '0);
`ifdef ALU_MC_HI_EN
          r_hi     <= w_rem;
`endif
        end
      end
    end
  end

  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_MUL) || (r_state == S_DIV);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
`ifdef ALU_MC_HI_EN
  assign bus.result_hi = r_hi;
`endif
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed vectors, expectations queued at accept, checked on output transfer.
module tb_alu_mc;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q_res[$];
  logic [W-1:0] q_hi[$];
  string        q_name[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a result transfers on the next rising edge when out_valid && out_ready.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q_res.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%08h required=none", bus.result);
      end else begin
        logic [W-1:0] er;
        logic [W-1:0] eh;
        string        nm;
        er = q_res.pop_front();
        eh = q_hi.pop_front();
        nm = q_name.pop_front();
        check({nm, "_result"}, bus.result, er);
        check({nm, "_zero"}, {{(W-1){1'b0}}, bus.zero}, {{(W-1){1'b0}}, (er == '0)});
`ifdef ALU_MC_HI_EN
        check({nm, "_hi"}, bus.result_hi, eh);
`endif
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] er, input logic [W-1:0] eh, input string name);
    int unsigned n;
    logic        acc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.a        = a;
    bus.b        = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      n++;
    end
    if (acc) begin
      q_res.push_back(er);
      q_hi.push_back(eh);
      q_name.push_back(name);
    end else begin
      checks++;
      failures++;
      $display("FAIL %s_accept actual=timeout required=in_ready", name);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = ~b;
    bus.alu_op   = ~op;
  endtask

  task automatic wait_out(input int exp_lat, input string name, output int busy_cnt);
    int lat;
    lat      = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy === 1'b1) busy_cnt++;
    end while (bus.out_valid !== 1'b1 && lat < 100);
    check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic [W-1:0] eh, input int lat,
                        input string name);
    int bc;
    send(op, a, b, er, eh, name);
    wait_out(lat, name, bc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.alu_op   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'b0, bus.zero}, 32'd1);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    run_op(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1, "add_wrap");
    @(negedge clk);
    check("add_after_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("add_after_in_ready", {31'b0, bus.in_ready}, 32'd1);

    send(4'b0010, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 32'h0, "mul");
    wait_out(33, "mul", bc);
    check("mul_busy_cycles", bc, 32);

    run_op(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33, "mul_max");
    run_op(4'b0011, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu");
    run_op(4'b0011, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 33, "divu_zero");
    run_op(4'b1101, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 32'h0, 1, "sra");
    run_op(4'b1110, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 32'h0, 1, "lt");
    run_op(4'b1010, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 32'h0, 1, "ltu");
    run_op(4'b1111, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 32'h0, 1, "ge");
    run_op(4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 32'h0, 1, "geu");
    run_op(4'b0001, 32'd9, 32'd9, 32'd0, 32'h0, 1, "sub_zero");
    run_op(4'b1100, 32'h0000_1001, 32'h0000_0002, 32'h0000_1002, 32'h0, 1, "jalr");
    run_op(4'b0111, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32'h0, 1, "sll");
    run_op(4'b1000, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 32'h0, 1, "srl");
    run_op(4'b1001, 32'd5, 32'd5, 32'd1, 32'h0, 1, "eq");

    // Back-pressure, then back-to-back accept on the consuming edge
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    run_op(4'b0110, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 32'h0, 1, "xor");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_result", bus.result, 32'h0000_0FF0);
      check("bp_zero", {31'b0, bus.zero}, 32'd0);
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alu_op    = 4'b0000;
    bus.a         = 32'd1;
    bus.b         = 32'd1;
    @(negedge clk);
    check("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    q_res.push_back(32'd2);
    q_hi.push_back(32'd0);
    q_name.push_back("b2b_add");
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEAD_BEEF;
    @(negedge clk);
    check("b2b_out_valid", {31'b0, bus.out_valid}, 32'd1);

    // Reset in the middle of a multiply
    send(4'b0010, 32'd3, 32'd5, 32'd15, 32'd0, "mul_aborted");
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (q_res.size() > 0) begin
      void'(q_res.pop_back());
      void'(q_hi.pop_back());
      void'(q_name.pop_back());
    end
    @(negedge clk);
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_zero", {31'b0, bus.zero}, 32'd1);
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    run_op(4'b0000, 32'd2, 32'd3, 32'd5, 32'h0, 1, "add_after_rst");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q_res.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
